// File: rtl/dat_block_sequencer_if.sv
// dat_block_sequencer_if: host/FIFO/dat_phys handshake bundle for the DAT block sequencer.
interface dat_block_sequencer_if #(
    parameter int BLOCK_W = 4,
    parameter int TO_W    = 16
);
    logic               start;
    logic [BLOCK_W-1:0] blocks;
    logic               write_read;
    logic               multiple;
    logic [TO_W-1:0]    timeout_reg;
    logic               abort;
    logic               fifo_ready;
    logic               phys_complete;
    logic               phys_crc_ok;
    logic               phys_strobe;
    logic               phys_ack;
    logic               phys_idle;
    logic               phys_write;
    logic               busy;
    logic [BLOCK_W-1:0] blocks_done;
    logic               transfer_done;
    logic               timeout_err;
    logic               crc_err;
    logic               aborted;

    modport master (
        output start, blocks, write_read, multiple, timeout_reg, abort, fifo_ready,
               phys_complete, phys_crc_ok,
        input  phys_strobe, phys_ack, phys_idle, phys_write, busy, blocks_done,
               transfer_done, timeout_err, crc_err, aborted
    );
    modport slave (
        input  start, blocks, write_read, multiple, timeout_reg, abort, fifo_ready,
               phys_complete, phys_crc_ok,
        output phys_strobe, phys_ack, phys_idle, phys_write, busy, blocks_done,
               transfer_done, timeout_err, crc_err, aborted
    );
endinterface

// File: rtl/dat_block_sequencer.sv
// dat_block_sequencer: sequences single/multi-block DAT transfers through dat_phys with timeout, CRC check and inter-block gap.
module dat_block_sequencer #(
    parameter int BLOCK_W    = 4,
    parameter int TO_W       = 16,
    parameter int GAP_CYCLES = 2
) (
    input logic sd_clock,
    input logic reset,
    dat_block_sequencer_if.slave bus
);
    localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_FIFO, STROBE, TRANSFER, CHECK, GAP, DONE, ERROR} state_t;

    state_t             state_q;
    logic [TO_W-1:0]    cnt_q, to_q;
    logic [GAP_W-1:0]   gap_q;
    logic [BLOCK_W-1:0] eff_q, blocks_done_q, blocks_done_d;
    logic               write_q, crc_q;
    logic               strobe_q, ack_q, idle_q, done_q;
    logic               timeout_err_q, crc_err_q, aborted_q;

    assign blocks_done_d = blocks_done_q + BLOCK_W'(1);

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            to_q          <= '0;
            gap_q         <= '0;
            eff_q         <= '0;
            blocks_done_q <= '0;
            write_q       <= 1'b0;
            crc_q         <= 1'b0;
            strobe_q      <= 1'b0;
            ack_q         <= 1'b0;
            idle_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            crc_err_q     <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            ack_q    <= 1'b0;
            idle_q   <= 1'b0;
            done_q   <= 1'b0;
            if (bus.abort && state_q != IDLE) begin
                state_q   <= IDLE;
                aborted_q <= 1'b1;
                idle_q    <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (bus.start) begin
                        blocks_done_q <= '0;
                        timeout_err_q <= 1'b0;
                        crc_err_q     <= 1'b0;
                        aborted_q     <= 1'b0;
                        write_q       <= bus.write_read;
                        to_q          <= bus.timeout_reg;
                        eff_q         <= bus.multiple ? bus.blocks : BLOCK_W'(1);
                        state_q       <= (bus.multiple && bus.blocks == '0) ? DONE : WAIT_FIFO;
                    end
                    WAIT_FIFO: begin
                        cnt_q <= '0;
                        if (bus.fifo_ready) begin
                            state_q  <= STROBE;
                            strobe_q <= 1'b1;
                        end
                    end
                    STROBE: begin
                        cnt_q   <= '0;
                        state_q <= TRANSFER;
                    end
                    // completion takes priority over a timeout expiring in the same cycle
                    TRANSFER: if (bus.phys_complete) begin
                        crc_q   <= bus.phys_crc_ok;
                        state_q <= CHECK;
                    end else if (to_q != '0 && cnt_q == to_q - TO_W'(1)) begin
                        timeout_err_q <= 1'b1;
                        idle_q        <= 1'b1;
                        state_q       <= ERROR;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                    CHECK: if (!crc_q) begin
                        crc_err_q <= 1'b1;
                        idle_q    <= 1'b1;
                        state_q   <= ERROR;
                    end else begin
                        ack_q         <= 1'b1;
                        blocks_done_q <= blocks_done_d;
                        idle_q        <= blocks_done_d != eff_q;
                        gap_q         <= GAP_W'(GAP_CYCLES - 1);
                        state_q       <= blocks_done_d == eff_q ? DONE : GAP;
                    end
                    GAP: if (gap_q == '0) begin
                        state_q <= WAIT_FIFO;
                    end else begin
                        gap_q  <= gap_q - GAP_W'(1);
                        idle_q <= 1'b1;
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    ERROR: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.phys_strobe   = strobe_q;
    assign bus.phys_ack      = ack_q;
    assign bus.phys_idle     = idle_q;
    assign bus.phys_write    = write_q;
    assign bus.busy          = state_q != IDLE;
    assign bus.blocks_done   = blocks_done_q;
    assign bus.transfer_done = done_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.crc_err       = crc_err_q;
    assign bus.aborted       = aborted_q;
endmodule

// File: tb/tb_dat_block_sequencer.sv
// tb_dat_block_sequencer: directed scenario tasks for dat_block_sequencer.
module tb_dat_block_sequencer;
    logic sd_clock = 1'b0;
    logic reset    = 1'b1;
    int   passed   = 0;
    int   total    = 0;
    int   n_strobe = 0;
    int   n_ack    = 0;
    int   n_done   = 0;

    dat_block_sequencer_if #(.BLOCK_W(4), .TO_W(16)) bus ();

    dat_block_sequencer #(.BLOCK_W(4), .TO_W(16), .GAP_CYCLES(2)) dut (
        .sd_clock(sd_clock),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sd_clock = ~sd_clock;

    always @(posedge sd_clock) begin
        if (bus.phys_strobe)   n_strobe++;
        if (bus.phys_ack)      n_ack++;
        if (bus.transfer_done) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge sd_clock);
        #1;
    endtask

    task automatic start_xfer(input logic [3:0] b, input logic m, input logic wr, input logic [15:0] to);
        bus.blocks      = b;
        bus.multiple    = m;
        bus.write_read  = wr;
        bus.timeout_reg = to;
        bus.start       = 1'b1;
        step();
        bus.start       = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            step();
            ok = bus.phys_strobe;
        end
    endtask

    task automatic complete_after(input int delay, input logic crc);
        repeat (delay) step();
        bus.phys_complete = 1'b1;
        bus.phys_crc_ok   = crc;
        step();
        bus.phys_complete = 1'b0;
        bus.phys_crc_ok   = 1'b0;
    endtask

    function automatic logic [12:0] outs();
        return {bus.phys_strobe, bus.phys_ack, bus.phys_idle, bus.phys_write, bus.busy,
                bus.blocks_done, bus.transfer_done, bus.timeout_err, bus.crc_err, bus.aborted};
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++; if (outs() !== 13'h0) $display("FAIL reset_outputs: got %h want 0", outs()); else passed++;
    endtask

    task automatic test_multi;
        int s0 = n_strobe, a0 = n_ack, d0 = n_done;
        bit ok;
        bus.fifo_ready = 1'b1;
        start_xfer(4'd4, 1'b1, 1'b1, 16'd0);
        total++; if (bus.busy !== 1'b1) $display("FAIL multi_busy: got %b want 1", bus.busy); else passed++;
        total++; if (bus.phys_write !== 1'b1) $display("FAIL multi_write: got %b want 1", bus.phys_write); else passed++;
        for (int k = 0; k < 4; k++) begin
            wait_strobe(ok);
            total++; if (!ok) $display("FAIL multi_strobe%0d: got none want pulse", k); else passed++;
            complete_after(10, 1'b1);
            step();
            total++; if (bus.phys_ack !== 1'b1) $display("FAIL multi_ack%0d: got %b want 1", k, bus.phys_ack); else passed++;
            total++; if (bus.blocks_done !== 4'(k + 1)) $display("FAIL multi_count%0d: got %0d want %0d", k, bus.blocks_done, k + 1); else passed++;
            if (k < 3) begin
                total++; if (bus.phys_idle !== 1'b1) $display("FAIL multi_gap%0d_a: got %b want 1", k, bus.phys_idle); else passed++;
                step();
                total++; if (bus.phys_idle !== 1'b1) $display("FAIL multi_gap%0d_b: got %b want 1", k, bus.phys_idle); else passed++;
                step();
                total++; if (bus.phys_idle !== 1'b0) $display("FAIL multi_gap%0d_end: got %b want 0", k, bus.phys_idle); else passed++;
            end else begin
                step();
                total++; if (bus.transfer_done !== 1'b1 || bus.busy !== 1'b0)
                    $display("FAIL multi_done: got done=%b busy=%b want done=1 busy=0", bus.transfer_done, bus.busy); else passed++;
            end
        end
        step();
        step();
        total++; if (n_strobe - s0 != 4) $display("FAIL multi_nstrobe: got %0d want 4", n_strobe - s0); else passed++;
        total++; if (n_ack - a0 != 4) $display("FAIL multi_nack: got %0d want 4", n_ack - a0); else passed++;
        total++; if (n_done - d0 != 1) $display("FAIL multi_ndone: got %0d want 1", n_done - d0); else passed++;
    endtask

    task automatic test_single;
        int s0 = n_strobe;
        bit ok;
        start_xfer(4'd4, 1'b0, 1'b0, 16'd0);
        wait_strobe(ok);
        complete_after(10, 1'b1);
        step();
        total++; if (bus.blocks_done !== 4'd1) $display("FAIL single_count: got %0d want 1", bus.blocks_done); else passed++;
        step();
        total++; if (bus.transfer_done !== 1'b1) $display("FAIL single_done: got %b want 1", bus.transfer_done); else passed++;
        repeat (10) step();
        total++; if (n_strobe - s0 != 1) $display("FAIL single_nstrobe: got %0d want 1", n_strobe - s0); else passed++;
    endtask

    task automatic test_timeout;
        int a0 = n_ack, k = 0;
        bit ok;
        start_xfer(4'd1, 1'b1, 1'b0, 16'd100);
        wait_strobe(ok);
        while (k < 300 && !bus.timeout_err) begin
            step();
            k++;
        end
        total++; if (k != 101) $display("FAIL timeout_latency: got %0d want 101", k); else passed++;
        total++; if (bus.busy !== 1'b1 || bus.phys_idle !== 1'b1)
            $display("FAIL timeout_error_state: got busy=%b idle=%b want 1 1", bus.busy, bus.phys_idle); else passed++;
        step();
        total++; if (bus.busy !== 1'b0 || bus.phys_idle !== 1'b0)
            $display("FAIL timeout_idle: got busy=%b idle=%b want 0 0", bus.busy, bus.phys_idle); else passed++;
        total++; if (n_ack - a0 != 0) $display("FAIL timeout_nack: got %0d want 0", n_ack - a0); else passed++;
    endtask

    task automatic test_crc;
        int a0 = n_ack, d0 = n_done;
        bit ok;
        start_xfer(4'd3, 1'b1, 1'b0, 16'd0);
        wait_strobe(ok);
        complete_after(10, 1'b1);
        wait_strobe(ok);
        total++; if (!ok) $display("FAIL crc_strobe2: got none want pulse"); else passed++;
        complete_after(10, 1'b0);
        step();
        total++; if (bus.crc_err !== 1'b1) $display("FAIL crc_err: got %b want 1", bus.crc_err); else passed++;
        total++; if (bus.blocks_done !== 4'd1) $display("FAIL crc_count: got %0d want 1", bus.blocks_done); else passed++;
        repeat (3) step();
        total++; if (bus.busy !== 1'b0 || bus.crc_err !== 1'b1)
            $display("FAIL crc_end: got busy=%b crc_err=%b want 0 1", bus.busy, bus.crc_err); else passed++;
        total++; if (n_done - d0 != 0 || n_ack - a0 != 1)
            $display("FAIL crc_pulses: got done=%0d ack=%0d want 0 1", n_done - d0, n_ack - a0); else passed++;
    endtask

    task automatic test_fifo_stall;
        bit ok;
        bit seen = 1'b0;
        start_xfer(4'd2, 1'b1, 1'b0, 16'd30);
        wait_strobe(ok);
        complete_after(10, 1'b1);
        bus.fifo_ready = 1'b0;
        step();
        repeat (20) begin
            step();
            if (bus.phys_strobe) seen = 1'b1;
        end
        total++; if (seen) $display("FAIL stall_strobe: got strobe want none"); else passed++;
        total++; if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL stall_state: got timeout=%b busy=%b want 0 1", bus.timeout_err, bus.busy); else passed++;
        bus.fifo_ready = 1'b1;
        step();
        total++; if (bus.phys_strobe !== 1'b1) $display("FAIL stall_resume: got %b want 1", bus.phys_strobe); else passed++;
        complete_after(10, 1'b1);
        step();
        step();
        total++; if (bus.transfer_done !== 1'b1 || bus.blocks_done !== 4'd2 || bus.timeout_err !== 1'b0)
            $display("FAIL stall_done: got done=%b count=%0d timeout=%b want 1 2 0",
                     bus.transfer_done, bus.blocks_done, bus.timeout_err); else passed++;
    endtask

    task automatic test_abort;
        int a0 = n_ack;
        bit ok;
        start_xfer(4'd2, 1'b1, 1'b0, 16'd0);
        wait_strobe(ok);
        repeat (5) step();
        bus.phys_complete = 1'b1;
        bus.phys_crc_ok   = 1'b1;
        bus.abort         = 1'b1;
        step();
        bus.phys_complete = 1'b0;
        bus.phys_crc_ok   = 1'b0;
        bus.abort         = 1'b0;
        total++; if (bus.aborted !== 1'b1 || bus.busy !== 1'b0 || bus.phys_idle !== 1'b1)
            $display("FAIL abort_state: got aborted=%b busy=%b idle=%b want 1 0 1", bus.aborted, bus.busy, bus.phys_idle); else passed++;
        step();
        total++; if (bus.phys_idle !== 1'b0 || bus.phys_ack !== 1'b0 || n_ack != a0)
            $display("FAIL abort_after: got idle=%b ack=%b nack=%0d want 0 0 0", bus.phys_idle, bus.phys_ack, n_ack - a0); else passed++;
        start_xfer(4'd1, 1'b1, 1'b0, 16'd0);
        total++; if (bus.aborted !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL abort_clear: got aborted=%b busy=%b want 0 1", bus.aborted, bus.busy); else passed++;
        wait_strobe(ok);
        complete_after(10, 1'b1);
        step();
        step();
        total++; if (bus.transfer_done !== 1'b1) $display("FAIL abort_rerun: got %b want 1", bus.transfer_done); else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        start_xfer(4'd2, 1'b1, 1'b1, 16'd0);
        wait_strobe(ok);
        repeat (3) step();
        reset = 1'b1;
        step();
        total++; if (outs() !== 13'h0) $display("FAIL midreset_outputs: got %h want 0", outs()); else passed++;
        reset = 1'b0;
        start_xfer(4'd1, 1'b1, 1'b0, 16'd0);
        wait_strobe(ok);
        total++; if (!ok) $display("FAIL midreset_strobe: got none want pulse"); else passed++;
        complete_after(4, 1'b1);
        step();
        total++; if (bus.phys_ack !== 1'b1 || bus.blocks_done !== 4'd1)
            $display("FAIL midreset_ack: got ack=%b count=%0d want 1 1", bus.phys_ack, bus.blocks_done); else passed++;
        step();
        total++; if (bus.transfer_done !== 1'b1) $display("FAIL midreset_done: got %b want 1", bus.transfer_done); else passed++;
    endtask

    task automatic test_zero_blocks;
        int s0 = n_strobe;
        start_xfer(4'd0, 1'b1, 1'b0, 16'd0);
        total++; if (bus.busy !== 1'b1 || bus.transfer_done !== 1'b0)
            $display("FAIL zero_first: got busy=%b done=%b want 1 0", bus.busy, bus.transfer_done); else passed++;
        step();
        total++; if (bus.transfer_done !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL zero_done: got done=%b busy=%b want 1 0", bus.transfer_done, bus.busy); else passed++;
        step();
        total++; if (n_strobe != s0) $display("FAIL zero_nstrobe: got %0d want 0", n_strobe - s0); else passed++;
    endtask

    initial begin
        bus.start         = 1'b0;
        bus.blocks        = '0;
        bus.write_read    = 1'b0;
        bus.multiple      = 1'b0;
        bus.timeout_reg   = '0;
        bus.abort         = 1'b0;
        bus.fifo_ready    = 1'b0;
        bus.phys_complete = 1'b0;
        bus.phys_crc_ok   = 1'b0;
        test_reset();
        test_multi();
        test_single();
        test_timeout();
        test_crc();
        test_fifo_stall();
        test_abort();
        test_reset_mid();
        test_zero_blocks();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
